// File: rtl/logic_unit_stream.sv
// logic_unit_stream: bitwise logic unit with a valid/ready input handshake
// and a circular output FIFO feeding a valid/ready writeback port.
// Optional feature macro: LOGIC_UNIT_FLAGS_EN stores zero/parity status with
// each result and reports it for the head entry; when it is undefined the
// status ports are present but tied to 0.
module logic_unit_stream #(
  parameter  int In_Data_Width = 8,
  parameter  int Fifo_Depth    = 4,
  localparam int Lvl_Width     = $clog2(Fifo_Depth) + 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [In_Data_Width-1:0] A,
  input  logic [In_Data_Width-1:0] B,
  input  logic [2:0]               Alu_fun,
  input  logic                     logic_enable,
  output logic                     logic_ready,
  output logic [In_Data_Width-1:0] logic_out,
  output logic                     logic_flag,
  input  logic                     out_ready,
  output logic                     zero_flag,
  output logic                     parity_flag,
  output logic [Lvl_Width-1:0]     logic_level
);

  localparam int Ptr_Width = $clog2(Fifo_Depth);
`ifdef LOGIC_UNIT_FLAGS_EN
  // Entry layout: {parity, zero, result}
  localparam int Entry_Width = In_Data_Width + 2;
`else
  localparam int Entry_Width = In_Data_Width;
`endif

  // Bitwise function selected by the ALU decoder.
  function automatic logic [In_Data_Width-1:0] f_logic(
    input logic [In_Data_Width-1:0] a,
    input logic [In_Data_Width-1:0] b,
    input logic [2:0]               fun
  );
    logic [In_Data_Width-1:0] r;
    case (fun)
      3'b000:  r = a & b;
      3'b001:  r = a | b;
      3'b010:  r = ~(a & b);
      3'b011:  r = ~(a | b);
      3'b100:  r = a ^ b;
      3'b101:  r = ~(a ^ b);
      3'b110:  r = ~a;
      3'b111:  r = a & ~b;
      default: r = {In_Data_Width{1'b0}};
    endcase
    return r;
  endfunction

  // Even-parity helper: XOR reduction of the result.
  function automatic logic f_parity(input logic [In_Data_Width-1:0] d);
    return ^d;
  endfunction

  // Zero detect helper.
  function automatic logic f_zero(input logic [In_Data_Width-1:0] d);
    return (d == {In_Data_Width{1'b0}});
  endfunction

  logic [Entry_Width-1:0]   mem_q [Fifo_Depth];
  logic [Ptr_Width-1:0]     rd_ptr_q, rd_ptr_d;
  logic [Ptr_Width-1:0]     wr_ptr_q, wr_ptr_d;
  logic [Lvl_Width-1:0]     level_q, level_d;
  logic                     ready_s;
  logic                     valid_s;
  logic                     accept_s;
  logic                     pop_s;
  logic [In_Data_Width-1:0] result_s;
  logic [Entry_Width-1:0]   entry_s;
  logic [Entry_Width-1:0]   head_s;

  // Ready and valid depend only on the registered level, so a full FIFO never
  // accepts even when a pop happens in the same cycle.
  assign ready_s  = (level_q < Lvl_Width'(Fifo_Depth));
  assign valid_s  = (level_q != {Lvl_Width{1'b0}});
  assign accept_s = logic_enable && ready_s;
  assign pop_s    = valid_s && out_ready;
  assign result_s = f_logic(A, B, Alu_fun);

`ifdef LOGIC_UNIT_FLAGS_EN
  assign entry_s = {f_parity(result_s), f_zero(result_s), result_s};
`else
  assign entry_s = result_s;
`endif

  // Next-state for pointers (wrap by natural overflow, depth is a power of
  // two) and occupancy level.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (accept_s) begin
      wr_ptr_d = wr_ptr_q + {{(Ptr_Width-1){1'b0}}, 1'b1};
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + {{(Ptr_Width-1){1'b0}}, 1'b1};
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({accept_s, pop_s})
      2'b10:   level_d = level_q + {{(Lvl_Width-1){1'b0}}, 1'b1};
      2'b01:   level_d = level_q - {{(Lvl_Width-1){1'b0}}, 1'b1};
      default: level_d = level_q;
    endcase
  end

  // Control state with synchronous active-low reset taking priority.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr_q <= {Ptr_Width{1'b0}};
      wr_ptr_q <= {Ptr_Width{1'b0}};
      level_q  <= {Lvl_Width{1'b0}};
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage write at the tail; contents are left alone on reset because the
  // level counter alone decides what is valid.
  always_ff @(posedge clk) begin
    if (rst && accept_s) begin
      mem_q[wr_ptr_q] <= entry_s;
    end
  end

  assign head_s = mem_q[rd_ptr_q];

  // Head outputs come straight from storage and are blanked while empty.
  assign logic_ready = ready_s;
  assign logic_flag  = valid_s;
  assign logic_level = level_q;
  assign logic_out   = valid_s ? head_s[In_Data_Width-1:0] : {In_Data_Width{1'b0}};
`ifdef LOGIC_UNIT_FLAGS_EN
  assign zero_flag   = valid_s ? head_s[In_Data_Width]     : 1'b0;
  assign parity_flag = valid_s ? head_s[In_Data_Width + 1] : 1'b0;
`else
  assign zero_flag   = 1'b0;
  assign parity_flag = 1'b0;
`endif

endmodule

// File: tb/tb_logic_unit_stream.sv
// Directed self-checking bench for logic_unit_stream (default parameters).
module tb_logic_unit_stream;

  logic       clk;
  logic       rst;
  logic [7:0] A;
  logic [7:0] B;
  logic [2:0] Alu_fun;
  logic       logic_enable;
  logic       logic_ready;
  logic [7:0] logic_out;
  logic       logic_flag;
  logic       out_ready;
  logic       zero_flag;
  logic       parity_flag;
  logic [2:0] logic_level;

  int checks;
  int failures;

  logic_unit_stream dut (
    .clk          (clk),
    .rst          (rst),
    .A            (A),
    .B            (B),
    .Alu_fun      (Alu_fun),
    .logic_enable (logic_enable),
    .logic_ready  (logic_ready),
    .logic_out    (logic_out),
    .logic_flag   (logic_flag),
    .out_ready    (out_ready),
    .zero_flag    (zero_flag),
    .parity_flag  (parity_flag),
    .logic_level  (logic_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_head(input string tag, input logic [7:0] d, input logic f, input logic [2:0] lvl);
    check({tag, "_out"}, {24'd0, logic_out}, {24'd0, d});
    check({tag, "_flag"}, {31'd0, logic_flag}, {31'd0, f});
    check({tag, "_lvl"}, {29'd0, logic_level}, {29'd0, lvl});
  endtask

  logic [7:0] sweep_exp [8];
  logic [7:0] fill_exp [4];

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b0; A = 8'h00; B = 8'h00; Alu_fun = 3'd0;
    logic_enable = 1'b0; out_ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
    #1;
    check_head("reset", 8'h00, 1'b0, 3'd0);
    check("reset_ready", {31'd0, logic_ready}, 32'd1);
    check("reset_zero", {31'd0, zero_flag}, 32'd0);
    check("reset_par", {31'd0, parity_flag}, 32'd0);

    // Function sweep, back-to-back with out_ready held high.
    sweep_exp[0] = 8'h00; sweep_exp[1] = 8'hFF; sweep_exp[2] = 8'hFF; sweep_exp[3] = 8'h00;
    sweep_exp[4] = 8'hFF; sweep_exp[5] = 8'h00; sweep_exp[6] = 8'h3A; sweep_exp[7] = 8'hC5;
    A = 8'hC5; B = 8'h3A; out_ready = 1'b1; logic_enable = 1'b1;
    for (int f = 0; f < 8; f++) begin
      Alu_fun = 3'(f);
      tick();
      check_head($sformatf("sweep%0d", f), sweep_exp[f], 1'b1, 3'd1);
    end
    logic_enable = 1'b0;
    tick();
    check_head("sweep_drain", 8'h00, 1'b0, 3'd0);

    // Fill with out_ready low.
    fill_exp[0] = 8'h10; fill_exp[1] = 8'h36; fill_exp[2] = 8'hEF; fill_exp[3] = 8'hC9;
    A = 8'h12; B = 8'h34; out_ready = 1'b0; logic_enable = 1'b1;
    for (int i = 0; i < 4; i++) begin
      Alu_fun = 3'(i);
      tick();
      check_head($sformatf("fill%0d", i), 8'h10, 1'b1, 3'(i + 1));
    end
    check("full_ready", {31'd0, logic_ready}, 32'd0);
    // Fifth request while full is dropped.
    Alu_fun = 3'd4;
    tick();
    check_head("drop", 8'h10, 1'b1, 3'd4);
    // Full + pop + enable: pop only.
    out_ready = 1'b1;
    tick();
    check_head("fullpop", fill_exp[1], 1'b1, 3'd3);
    check("fullpop_ready", {31'd0, logic_ready}, 32'd1);
    // Now accepted (XOR 12^34 = 26) together with a pop.
    tick();
    check_head("acc_pop", fill_exp[2], 1'b1, 3'd3);
    logic_enable = 1'b0;
    tick();
    check_head("drain1", fill_exp[3], 1'b1, 3'd2);
    tick();
    check_head("drain2", 8'h26, 1'b1, 3'd1);
    tick();
    check_head("drain3", 8'h00, 1'b0, 3'd0);

    // Status flags.
    A = 8'hF0; B = 8'h0F; Alu_fun = 3'd0; logic_enable = 1'b1;
    tick();
    check_head("fl_and", 8'h00, 1'b1, 3'd1);
`ifdef LOGIC_UNIT_FLAGS_EN
    check("fl_and_zero", {31'd0, zero_flag}, 32'd1);
`else
    check("fl_and_zero", {31'd0, zero_flag}, 32'd0);
`endif
    check("fl_and_par", {31'd0, parity_flag}, 32'd0);
    Alu_fun = 3'd4;
    tick();
    check_head("fl_xor", 8'hFF, 1'b1, 3'd1);
    check("fl_xor_zero", {31'd0, zero_flag}, 32'd0);
    check("fl_xor_par", {31'd0, parity_flag}, 32'd0);
    A = 8'hFE; Alu_fun = 3'd6;
    tick();
    check_head("fl_not", 8'h01, 1'b1, 3'd1);
    check("fl_not_zero", {31'd0, zero_flag}, 32'd0);
`ifdef LOGIC_UNIT_FLAGS_EN
    check("fl_not_par", {31'd0, parity_flag}, 32'd1);
`else
    check("fl_not_par", {31'd0, parity_flag}, 32'd0);
`endif
    logic_enable = 1'b0;
    tick();
    check_head("fl_drain", 8'h00, 1'b0, 3'd0);

    // Reset mid-stream with three queued results.
    A = 8'h55; B = 8'h0F; out_ready = 1'b0; logic_enable = 1'b1;
    Alu_fun = 3'd0; tick();
    Alu_fun = 3'd1; tick();
    Alu_fun = 3'd4; tick();
    check_head("pre_rst", 8'h05, 1'b1, 3'd3);
    logic_enable = 1'b0; rst = 1'b0;
    tick();
    check_head("mid_rst", 8'h00, 1'b0, 3'd0);
    rst = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_head($sformatf("post_rst%0d", i), 8'h00, 1'b0, 3'd0);
    end
    A = 8'h81; B = 8'h7E; Alu_fun = 3'd1; logic_enable = 1'b1;
    tick();
    check_head("post_acc", 8'hFF, 1'b1, 3'd1);
    logic_enable = 1'b0;
    tick();
    check_head("post_drain", 8'h00, 1'b0, 3'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/logic_unit_stream.md
# logic_unit_stream

Second-generation logic unit for the signed ALU datapath. Computes one of eight bitwise functions of two `In_Data_Width` operands per accepted transaction and queues results in a `Fifo_Depth`-entry output buffer. Valid/ready handshakes on both sides let the ALU decoder issue back-to-back operations while the writeback side applies backpressure. Optional zero/parity status travels with each result.

## Interface
Parameters:
- `In_Data_Width`, 8, operand and result width (≥1)
- `Fifo_Depth`, 4, output buffer entries (power of two, ≥2)
- `Lvl_Width`, `$clog2(Fifo_Depth)+1`, width of the occupancy output (derived, not overridden)

Ports (all in the `clk` domain):
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-low reset, sampled on `clk` rising edge
- `A` in In_Data_Width: operand A
- `B` in In_Data_Width: operand B
- `Alu_fun` in 3: function select
- `logic_enable` in 1: input valid
- `logic_ready` out 1: input ready
- `logic_out` out In_Data_Width: result at FIFO head
- `logic_flag` out 1: output valid
- `out_ready` in 1: downstream ready
- `zero_flag` out 1: head result == 0
- `parity_flag` out 1: XOR-reduce of head result
- `logic_level` out Lvl_Width: current FIFO occupancy, 0..Fifo_Depth

## Operation
- Accept: `logic_enable && logic_ready` at a rising edge. The result is computed combinationally from `A`/`B`/`Alu_fun` and written to the FIFO tail.
- Functions:
  - 000 A&B
  - 001 A|B
  - 010 ~(A&B)
  - 011 ~(A|B)
  - 100 A^B
  - 101 ~(A^B)
  - 110 ~A
  - 111 A&~B
- Pop: `logic_flag && out_ready` at a rising edge. The head advances.
- FIFO: circular buffer with read/write pointers wrapping modulo `Fifo_Depth`, plus an occupancy counter (`logic_level`).
- `logic_ready` = (level < Fifo_Depth).
  - Registered-state only; no combinational path from `out_ready`.
  - A full FIFO does not accept, even if a pop occurs in the same cycle.
- `logic_flag` = (level != 0).
- When `logic_flag` = 0: `logic_out`, `zero_flag` and `parity_flag` are driven 0.
- Simultaneous accept and pop (level not 0, not full): both occur and the level is unchanged.
- Accept into an empty FIFO with `out_ready` = 1: no bypass. The result appears the next cycle.
- `logic_enable` while not ready: the input is ignored and nothing is stored. The source must hold its data.
- Once `logic_flag` is asserted, the head data is stable until popped. The `logic_out`/flags outputs are driven directly from FIFO storage, not combinationally from the inputs.

## Timing
- Reset (`rst` = 0 at an edge):
  - level = 0, pointers = 0
  - `logic_flag` = 0, `logic_out` = 0, `zero_flag` = 0, `parity_flag` = 0, `logic_level` = 0
  - `logic_ready` = 1 from the first cycle after reset deasserts
  - Reset mid-stream discards all queued results; storage contents need not be cleared.
- Latency: accept at edge k → `logic_flag`/result visible after edge k (during cycle k+1) when the FIFO was empty.
- Throughput: 1 result/cycle sustained when `out_ready` = 1 continuously.
- Level changes:
  - +1 on accept-only
  - −1 on pop-only
  - 0 on both or neither
- Reset has priority over accept and pop.

## Configuration
- `LOGIC_UNIT_FLAGS_EN` defined:
  - Each FIFO entry stores result plus zero and parity bits, computed at accept time.
  - `zero_flag`/`parity_flag` report the head entry.
- Not defined:
  - Flag bits are not stored (FIFO width = In_Data_Width).
  - `zero_flag` and `parity_flag` are tied to 0.
  - Ports remain present.

## Test plan
- Reset, then check: `logic_level` = 0, `logic_flag` = 0, `logic_out` = 0, `logic_ready` = 1.
- Function sweep: `A` = 8'hC5, `B` = 8'h3A, `out_ready` = 1, `Alu_fun` = 0..7 back-to-back. Expect results 00, FF, FF, 00, FF, 00, 3A, C5 on consecutive cycles, one cycle after each accept.
- Fill with `out_ready` = 0: accept 4 ops (`Fifo_Depth` = 4), so `logic_level` = 4 and `logic_ready` = 0. A fifth `logic_enable` is dropped. Release `out_ready` and observe 4 results in order.
- Full FIFO + `out_ready` = 1 + `logic_enable` = 1 in the same cycle: the pop occurs, the input is not accepted, and the level goes 4→3. The next cycle accepts.
- Flags (macro on): `A` = 8'hF0, `B` = 8'h0F, AND gives `zero_flag` = 1, `parity_flag` = 0. XOR gives FF with `zero_flag` = 0, `parity_flag` = 0. `~A` with `A` = 8'hFE gives 01 with `parity_flag` = 1. With the macro off, both flags stay 0.
- Reset mid-stream with level = 3: the next cycle shows level 0, `logic_flag` 0, `logic_out` 0. No stale results emerge afterward.
